// File: rtl/sysmgr_pkg.sv
// sysmgr_pkg: shared types and helpers for the system-manager reset blocks.
// Holds the sequencer state encoding and the counter-width helper.
package sysmgr_pkg;

  // Sequencer states: outputs held, hold countdown, staggered release, all released.
  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REL    = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

  // Width of a counter that must reach max(hold, step) - 1 without wrapping.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int max_c;
    max_c = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return $clog2(max_c + 1);
  endfunction

endpackage

// File: rtl/sysmgr_rst_seq_if.sv
// sysmgr_rst_seq_if: control and status bundle of the reset sequencer.
// master = the system-manager controller side, slave = the sequencer.
interface sysmgr_rst_seq_if #(
  parameter int N_OUT = 3
);
  logic             ext_hold;
  logic             soft_req;
  logic             wdt_kick;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic             wdt_fired;

  modport master (
    output ext_hold, soft_req, wdt_kick,
    input  rst_out, ready, wdt_fired
  );

  modport slave (
    input  ext_hold, soft_req, wdt_kick,
    output rst_out, ready, wdt_fired
  );
endinterface

// File: rtl/sysmgr_rst_sync.sv
// sysmgr_rst_sync: STAGES-deep asynchronous-assert / synchronous-deassert
// reset synchroniser. Output is low immediately when rst_n falls and goes
// high STAGES clock edges after rst_n rises.
module sysmgr_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n_o
);

  logic [STAGES-1:0] sync_q;

  // Shift ones in from bit 0; the top bit is the synchronised reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(1);
    end
  end

  assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/sysmgr_rst_seq.sv
// sysmgr_rst_seq: parametrised reset sequencer. Releases N_OUT active-high
// resets in index order: HOLD cycles after the synchronised reset release,
// then one every STEP cycles. ext_hold forces everything back to asserted;
// soft_req in RUN re-runs the sequence from HOLD.
// Optional watchdog enabled by defining SYSMGR_WDT_EN.
module sysmgr_rst_seq
  import sysmgr_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int HOLD        = 240,
  parameter int STEP        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_CYCLES  = 1048576
) (
  input logic              clk,
  input logic              rst_n,
  sysmgr_rst_seq_if.slave  bus_if
);

  localparam int               CNT_W     = cnt_width(HOLD, STEP);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP - 1);

  logic             rst_sync_n;
  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_OUT-1:0] rst_out_q;
  logic [N_OUT-1:0] rel_d;
  logic             ready_q;
  logic             restart;
  logic             wdt_timeout;

  // The state flops act as the last synchroniser stage, so the chain in front
  // of them is one shorter: the FSM takes its first step on edge SYNC_STAGES.
  sysmgr_rst_sync #(
    .STAGES(SYNC_STAGES - 1)
  ) u_rst_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_sync_n_o (rst_sync_n)
  );

  // Releasing the next output is a left shift of the asserted mask, which
  // guarantees that outputs can only ever deassert in index order.
  assign rel_d   = rst_out_q << 1;
  assign restart = bus_if.soft_req | wdt_timeout;

  // Sequencer FSM with registered outputs; ext_hold outranks every other request.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else if (bus_if.ext_hold) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q     <= '0;
            rst_out_q <= rel_d;
            ready_q   <= (rel_d == '0);
            state_q   <= (rel_d == '0) ? ST_RUN : ST_REL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (cnt_q == STEP_LAST) begin
            cnt_q     <= '0;
            rst_out_q <= rel_d;
            ready_q   <= (rel_d == '0);
            state_q   <= (rel_d == '0) ? ST_RUN : ST_REL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (restart) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_ASSERT;
          cnt_q     <= '0;
          rst_out_q <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.rst_out = rst_out_q;
  assign bus_if.ready   = ready_q;

`ifdef SYSMGR_WDT_EN
  localparam int               WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_fired_q;

  // A kick in the terminal cycle wins; ext_hold suppresses the timeout entirely.
  assign wdt_timeout = (state_q == ST_RUN) && !bus_if.ext_hold &&
                       !bus_if.wdt_kick && (wdt_cnt_q == WDT_LAST);

  // Watchdog counter runs only in RUN; fired flag is sticky until rst_n.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      if ((state_q != ST_RUN) || bus_if.wdt_kick || wdt_timeout) begin
        wdt_cnt_q <= '0;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
      end
      if (wdt_timeout) begin
        wdt_fired_q <= 1'b1;
      end
    end
  end

  assign bus_if.wdt_fired = wdt_fired_q;
`else
  logic unused_wdt;

  assign wdt_timeout      = 1'b0;
  assign bus_if.wdt_fired = 1'b0;
  assign unused_wdt       = bus_if.wdt_kick ^ (WDT_CYCLES == 0);
`endif

endmodule
